// File: rtl/jam_perm_engine_if.sv
// Request/result and cost-table bundle of the permutation engine.
// The engine side uses the slave modport; the requester/cost table uses the master modport.
interface jam_perm_engine_if #(
  parameter int N   = 8,
  parameter int IW  = 3,
  parameter int CW  = 7,
  parameter int SW  = 10,
  parameter int MCW = 16
);
  logic            Start;
  logic            Busy;
  logic            Valid;
  logic [IW-1:0]   W;
  logic [IW-1:0]   J;
  logic [CW-1:0]   Cost;
  logic [SW-1:0]   MinCost;
  logic [MCW-1:0]  MatchCount;
  logic [N*IW-1:0] BestPerm;

  modport master (
    output Start, Cost,
    input  Busy, Valid, W, J, MinCost, MatchCount, BestPerm
  );

  modport slave (
    input  Start, Cost,
    output Busy, Valid, W, J, MinCost, MatchCount, BestPerm
  );
endinterface

// File: rtl/jam_perm_engine.sv
// Job-assignment engine: walks all N! permutations in lexicographic order, sums the external
// cost of each and keeps the minimum total, its tie count and the first permutation reaching it.
module jam_perm_engine #(
  parameter int N     = 8,
  parameter int IW    = 3,
  parameter int CW    = 7,
  parameter int SW    = 10,
  parameter int MCW   = 16,
  parameter int PRUNE = 0
) (
  input logic              CLK,
  input logic              RST_N,
  jam_perm_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CAL, CHECK, FIND_I, FIND_J, SWAP, REV, DONE
  } state_t;

  localparam logic [IW-1:0]  LAST        = IW'(N - 1);
  localparam logic [IW-1:0]  SECOND_LAST = IW'(N - 2);
  localparam logic [MCW-1:0] MC_MAX      = '1;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   seq [N];
  logic [IW-1:0]   k;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic [IW-1:0]   w_idx;
  logic [SW-1:0]   acc;
  logic [SW-1:0]   acc_sum;
  logic [SW-1:0]   min_cost;
  logic [MCW-1:0]  match_count;
  logic [N*IW-1:0] best_perm;
  logic            valid;
  logic            prune_hit;
  logic            rise_found;
  logic            swap_found;

  function automatic logic [N*IW-1:0] identity_perm();
    logic [N*IW-1:0] p;
    p = '0;
    for (int m = 0; m < N; m++) p[m*IW +: IW] = IW'(m);
    return p;
  endfunction

  assign acc_sum    = acc + SW'(bus.Cost);
  // A partial sum already above the best total can never tie or win, so the rest is skipped.
  assign prune_hit  = (PRUNE != 0) && (acc_sum > min_cost);
  assign rise_found = seq[i] < seq[i + 1'b1];
  assign swap_found = seq[j] > seq[i];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = CAL;
      CAL: begin
        if (prune_hit)      state_nxt = FIND_I;
        else if (k == LAST) state_nxt = CHECK;
      end
      CHECK:   state_nxt = FIND_I;
      FIND_I: begin
        if (rise_found)     state_nxt = FIND_J;
        else if (i == '0)   state_nxt = DONE;
      end
      FIND_J:  if (swap_found) state_nxt = SWAP;
      SWAP:    state_nxt = REV;
      REV:     state_nxt = CAL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cost table is only addressed during CAL; elsewhere it sees worker 0.
  always_comb begin
    w_idx = '0;
    if (state == CAL) w_idx = k;
    bus.W    = w_idx;
    bus.J    = seq[w_idx];
    bus.Busy = (state != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int m = 0; m < N; m++) seq[m] <= IW'(m);
      k           <= '0;
      i           <= '0;
      j           <= '0;
      acc         <= '0;
      min_cost    <= '1;
      match_count <= '0;
      best_perm   <= identity_perm();
      valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            for (int m = 0; m < N; m++) seq[m] <= IW'(m);
            k           <= '0;
            acc         <= '0;
            min_cost    <= '1;
            match_count <= '0;
            valid       <= 1'b0;
          end
        end
        CAL: begin
          acc <= acc_sum;
          k   <= k + 1'b1;
          if (prune_hit || (k == LAST)) i <= SECOND_LAST;
        end
        CHECK: begin
          if (acc < min_cost) begin
            min_cost    <= acc;
            match_count <= MCW'(1);
            for (int m = 0; m < N; m++) best_perm[m*IW +: IW] <= seq[m];
          end else if ((acc == min_cost) && (match_count != MC_MAX)) begin
            match_count <= match_count + 1'b1;
          end
        end
        FIND_I: begin
          if (rise_found) j <= LAST;
          else            i <= i - 1'b1;
        end
        FIND_J: begin
          if (!swap_found) j <= j - 1'b1;
        end
        SWAP: begin
          seq[i] <= seq[j];
          seq[j] <= seq[i];
        end
        REV: begin
          // The suffix after the pivot is descending; reversing it gives the next permutation.
          for (int m = 1; m < N; m++) begin
            if (m > int'(i)) seq[m] <= seq[IW'(N - 1 + int'(i) + 1 - m)];
          end
          k   <= '0;
          acc <= '0;
        end
        DONE:    valid <= 1'b1;
        default: valid <= valid;
      endcase
    end
  end

  assign bus.Valid      = valid;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match_count;
  assign bus.BestPerm   = best_perm;

endmodule

// File: tb/tb_jam_perm_engine.sv
// Bench for jam_perm_engine: a full-search instance and a pruning, narrow-count instance share
// one cost table; results go through a scoreboard fed by a brute-force enumeration model.
module tb_jam_perm_engine;

  localparam int N     = 5;
  localparam int IW    = 3;
  localparam int CW    = 7;
  localparam int SW    = 10;
  localparam int MCW0  = 16;
  localparam int MCW1  = 4;
  localparam int LIMIT = 4000;

  typedef struct {
    logic [SW-1:0]   min_cost;
    int              count;
    logic [N*IW-1:0] best;
  } exp_t;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cost_tab [N][N];

  exp_t q0[$];
  exp_t q1[$];
  exp_t last_e0;
  exp_t last_e1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  jam_perm_engine_if #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW0)) bus0 ();
  jam_perm_engine_if #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW1)) bus1 ();

  assign bus0.Start = start;
  assign bus1.Start = start;
  assign bus0.Cost  = cost_tab[bus0.W][bus0.J];
  assign bus1.Cost  = cost_tab[bus1.W][bus1.J];

  jam_perm_engine #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW0), .PRUNE(0)) u_full (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus0)
  );

  jam_perm_engine #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW1), .PRUNE(1)) u_prune (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus1)
  );

  function automatic logic [N*IW-1:0] identity();
    logic [N*IW-1:0] p;
    p = '0;
    for (int m = 0; m < N; m++) p[m*IW +: IW] = IW'(m);
    return p;
  endfunction

  // Counts base-N numbers upward with worker 0 as the top digit, keeping only those without
  // repeated digits: that visits every permutation exactly once in lexicographic order.
  function automatic exp_t model(input int mcw);
    exp_t e;
    int   perm [N];
    int   c, used, total, sat;
    bit   ok;
    e.min_cost = '1;
    e.count    = 0;
    e.best     = identity();
    for (int code = 0; code < N**N; code++) begin
      c = code; used = 0; ok = 1'b1; total = 0;
      for (int k = N - 1; k >= 0; k--) begin
        perm[k] = c % N;
        c = c / N;
      end
      for (int k = 0; k < N; k++) begin
        if (used[perm[k]]) ok = 1'b0;
        used[perm[k]] = 1'b1;
        total += int'(cost_tab[k][perm[k]]);
      end
      if (ok) begin
        if (total < int'(e.min_cost)) begin
          e.min_cost = SW'(total);
          e.count    = 1;
          for (int k = 0; k < N; k++) e.best[k*IW +: IW] = IW'(perm[k]);
        end else if (total == int'(e.min_cost)) begin
          e.count++;
        end
      end
    end
    sat = (1 << mcw) - 1;
    if (e.count > sat) e.count = sat;
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic checkResult(input string tag, input exp_t e, input longint mc,
                             input longint cnt, input longint best);
    checkOutput({tag, "_mincost"}, mc, longint'(e.min_cost));
    checkOutput({tag, "_count"}, cnt, longint'(e.count));
    checkOutput({tag, "_bestperm"}, best, longint'(e.best));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy0"}, bus0.Busy, 0);
    checkOutput({tag, "_valid0"}, bus0.Valid, 0);
    checkOutput({tag, "_w0"}, bus0.W, 0);
    checkOutput({tag, "_j0"}, bus0.J, 0);
    checkOutput({tag, "_mincost0"}, bus0.MinCost, (1 << SW) - 1);
    checkOutput({tag, "_count0"}, bus0.MatchCount, 0);
    checkOutput({tag, "_best0"}, bus0.BestPerm, identity());
    checkOutput({tag, "_busy1"}, bus1.Busy, 0);
    checkOutput({tag, "_valid1"}, bus1.Valid, 0);
    checkOutput({tag, "_mincost1"}, bus1.MinCost, (1 << SW) - 1);
    checkOutput({tag, "_count1"}, bus1.MatchCount, 0);
    checkOutput({tag, "_best1"}, bus1.BestPerm, identity());
  endtask

  // Pattern -1 keeps the current table so identical runs can be repeated.
  task automatic fillTable(input int pattern);
    for (int w = 0; w < N; w++) begin
      for (int jj = 0; jj < N; jj++) begin
        case (pattern)
          0:       cost_tab[w][jj] = CW'(5);
          1:       cost_tab[w][jj] = CW'((w > jj) ? w - jj : jj - w);
          2:       cost_tab[w][jj] = CW'((jj == N - 1 - w) ? 7 : 50);
          3:       cost_tab[w][jj] = CW'($urandom_range(0, 3));
          4:       cost_tab[w][jj] = CW'($urandom_range(0, 127));
          5:       cost_tab[w][jj] = CW'(127);
          6:       cost_tab[w][jj] = CW'($urandom_range(0, 1));
          default: cost_tab[w][jj] = cost_tab[w][jj];
        endcase
      end
    end
  endtask

  task automatic issueStart();
    last_e0 = model(MCW0);
    last_e1 = model(MCW1);
    q0.push_back(last_e0);
    q1.push_back(last_e1);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    checkOutput("busy_after_start0", bus0.Busy, 1);
    checkOutput("busy_after_start1", bus1.Busy, 1);
    checkOutput("valid_cleared0", bus0.Valid, 0);
  endtask

  task automatic applyStimulus(input int pattern, input int extra_start_at,
                               output int cyc0, output int cyc1);
    bit done0, done1;
    fillTable(pattern);
    issueStart();
    done0 = 1'b0; done1 = 1'b0; cyc0 = -1; cyc1 = -1;
    for (int cyc = 0; cyc < LIMIT && !(done0 && done1); cyc++) begin
      start = (cyc == extra_start_at);
      @(negedge CLK);
      if (!done0 && bus0.Valid) begin done0 = 1'b1; cyc0 = cyc; end
      if (!done1 && bus1.Valid) begin done1 = 1'b1; cyc1 = cyc; end
    end
    start = 1'b0;
    checkOutput("finish_full", done0, 1);
    checkOutput("finish_prune", done1, 1);
    repeat (3) @(negedge CLK);
    checkOutput("valid_hold0", bus0.Valid, 1);
    checkOutput("mincost_hold0", bus0.MinCost, longint'(last_e0.min_cost));
    checkOutput("count_hold1", bus1.MatchCount, longint'(last_e1.count));
    checkOutput("busy_idle0", bus0.Busy, 0);
  endtask

  initial begin : monitor
    bit   seen0, seen1;
    exp_t e;
    seen0 = 1'b0;
    seen1 = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        seen0 = 1'b0;
        seen1 = 1'b0;
      end else begin
        if (bus0.Valid && !seen0) begin
          seen0 = 1'b1;
          if (q0.size() == 0) checkOutput("unexpected_valid0", 1, 0);
          else begin
            e = q0.pop_front();
            checkResult("full", e, bus0.MinCost, bus0.MatchCount, bus0.BestPerm);
          end
        end
        if (!bus0.Valid) seen0 = 1'b0;
        if (bus1.Valid && !seen1) begin
          seen1 = 1'b1;
          if (q1.size() == 0) checkOutput("unexpected_valid1", 1, 0);
          else begin
            e = q1.pop_front();
            checkResult("prune", e, bus1.MinCost, bus1.MatchCount, bus1.BestPerm);
          end
        end
        if (!bus1.Valid) seen1 = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int c0, c1, r0, r1;
    fillTable(0);
    repeat (3) @(negedge CLK);
    checkReset("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    checkReset("post_rst");

    for (int p = 0; p <= 6; p++) begin
      applyStimulus(p, -1, c0, c1);
      checkOutput("prune_not_slower", (c1 <= c0) ? 1 : 0, 1);
      if (p == 1 || p == 2) checkOutput("prune_faster", (c1 < c0) ? 1 : 0, 1);
    end
    for (int n = 0; n < 3; n++) begin
      applyStimulus(3 + (n % 2), -1, c0, c1);
      checkOutput("prune_not_slower_rand", (c1 <= c0) ? 1 : 0, 1);
    end

    $display("[TB] reset during run and ignored Start");
    applyStimulus(4, -1, r0, r1);
    issueStart();
    repeat (200) @(negedge CLK);
    RST_N = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge CLK);
    checkReset("mid_rst");
    RST_N = 1'b1;
    @(negedge CLK);
    checkReset("mid_rst_release");
    applyStimulus(-1, -1, c0, c1);
    checkOutput("rerun_cycles0", c0, r0);
    checkOutput("rerun_cycles1", c1, r1);
    applyStimulus(-1, 50, c0, c1);
    checkOutput("busy_start_cycles0", c0, r0);
    checkOutput("busy_start_cycles1", c1, r1);

    @(negedge CLK);
    checkOutput("pending_full", q0.size(), 0);
    checkOutput("pending_prune", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
